// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: default sizing and run-control states.
package pc_sequencer_pkg;

  localparam int          WIDTH_DEF    = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  // Encoding 2'd3 is never entered; the sequencer treats it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the jump-condition/decode side (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             stall;
  logic             instr_valid;
  logic             jump_req;
  logic             jump_uncond;
  logic             cond_true;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc;
  logic             fetch_en;
  logic             jump_taken;
  logic             halted;
  logic [WIDTH-1:0] retired;

  modport master (
    output start, stall, instr_valid, jump_req, jump_uncond, cond_true, target,
    input  pc, fetch_en, jump_taken, halted, retired
  );

  modport slave (
    input  start, stall, instr_valid, jump_req, jump_uncond, cond_true, target,
    output pc, fetch_en, jump_taken, halted, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with run control, stall hold, self-loop halt detection and a
// saturating retired-instruction counter.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   ST_IDLE | out of reset; pc parked at RESET_PC, waiting for start
//   ST_RUN  | fetching; each unstalled valid instruction commits and moves pc
//   ST_HALT | program ended on an unconditional self-jump; pc/retired frozen
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF)
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] retired_q, retired_d;
  logic             jump_taken_q, jump_taken_d;

  logic             commit;
  logic             take;

  // State, PC, counter and jump pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      retired_q    <= '0;
      jump_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      retired_q    <= retired_d;
      jump_taken_q <= jump_taken_d;
    end
  end

  // Next-state: run control, next-PC mux, halt detect and saturating retire count.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    retired_d    = retired_q;
    jump_taken_d = 1'b0;
    commit       = 1'b0;
    take         = 1'b0;

    case (state_q)
      ST_RUN: begin
        commit = bus.instr_valid & ~bus.stall;
        take   = bus.jump_req & bus.cond_true;
        if (commit) begin
          retired_d = (&retired_q) ? retired_q : retired_q + WIDTH'(1);
          if (take) begin
            pc_d         = bus.target;
            jump_taken_d = 1'b1;
            // A conditional jump onto itself is an ordinary jump; only an
            // unconditional one marks the end of the program.
            if (bus.jump_uncond && (bus.target == pc_q)) begin
              state_d = ST_HALT;
            end
          end else begin
            pc_d = pc_q + WIDTH'(1);
          end
        end
      end
      ST_HALT: begin
        if (bus.start) begin
          state_d   = ST_RUN;
          pc_d      = RESET_PC;
          retired_d = '0;
        end
      end
      default: begin
        pc_d = RESET_PC;
        if (bus.start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Output drive; only fetch_en sees an input (stall) combinationally.
  always_comb begin
    bus.pc         = pc_q;
    bus.retired    = retired_q;
    bus.jump_taken = jump_taken_q;
    bus.halted     = (state_q == ST_HALT);
    bus.fetch_en   = (state_q == ST_RUN) & ~bus.stall;
  end

endmodule
